// File: rtl/bist_seq_ctrl_if.sv
// Host/CUT-side signal bundle of the BIST sequencer.
// Handshake: start/abort are level-sampled on the rising clock edge. There is no ready; start is ignored unless idle or done.
interface bist_seq_ctrl_if;
  logic        start;
  logic        abort;
  logic [5:0]  cut_out;
  logic        cut_g0;
  logic        cut_g1;
  logic        cut_g2;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  sign;
  logic [15:0] pat_cnt;

  modport master (
    output start, abort, cut_out,
    input  cut_g0, cut_g1, cut_g2, busy, done, pass, sign, pat_cnt
  );

  modport slave (
    input  start, abort, cut_out,
    output cut_g0, cut_g1, cut_g2, busy, done, pass, sign, pat_cnt
  );
endinterface

// File: rtl/bist_seq_ctrl.sv
// Self-test sequencer: clears the CUT, drives LFSR patterns, compacts the CUT outputs into a MISR,
// and compares the final signature against a golden value.
module bist_seq_ctrl #(
  parameter int unsigned N_PAT     = 255,
  parameter int unsigned INIT_CYC  = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [7:0]  MISR_SEED = 8'h00,
  parameter logic [7:0]  GOLDEN    = 8'h00
) (
  input  logic              i_ck,
  input  logic              i_rst,
  bist_seq_ctrl_if.slave    bus,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [7:0]  r_misr;
  logic [7:0]  r_init_cnt;
  logic [15:0] r_pat_cnt;

  logic [7:0]  w_lfsr_next;
  logic [7:0]  w_misr_next;
  logic [15:0] w_pat_inc;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_misr_next = {r_misr[6:0], r_misr[7] ^ r_misr[5] ^ r_misr[4] ^ r_misr[3]}
                       ^ {2'b00, bus.cut_out};
  assign w_pat_inc   = (r_pat_cnt == 16'hFFFF) ? r_pat_cnt : r_pat_cnt + 16'd1;

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= 8'h00;
      r_misr     <= 8'h00;
      r_init_cnt <= 8'h00;
      r_pat_cnt  <= 16'h0000;
    end else if (bus.abort) begin
      r_state <= S_IDLE;
      // The pattern on the pins during an aborted RUN cycle still counts as applied.
      if (r_state == S_RUN) r_pat_cnt <= w_pat_inc;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_INIT;
            r_lfsr     <= LFSR_SEED;
            r_misr     <= MISR_SEED;
            r_init_cnt <= 8'h00;
            r_pat_cnt  <= 16'h0000;
          end
        end
        S_INIT: begin
          if (r_init_cnt == 8'(INIT_CYC - 1)) r_state <= S_RUN;
          else                                 r_init_cnt <= r_init_cnt + 8'd1;
        end
        S_RUN: begin
          r_lfsr    <= w_lfsr_next;
          r_pat_cnt <= w_pat_inc;
          // CUT responses arrive one cycle after their stimulus, so the first RUN cycle has nothing to capture.
          if (r_pat_cnt != 16'h0000) r_misr <= w_misr_next;
          if (r_pat_cnt == 16'(N_PAT - 1)) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_misr  <= w_misr_next;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only from registers, so there is no combinational path from inputs to the CUT pins.
  assign bus.cut_g0  = (r_state == S_INIT);
  assign bus.cut_g1  = (r_state == S_RUN) & r_lfsr[0];
  assign bus.cut_g2  = (r_state == S_RUN) & r_lfsr[1];
  assign bus.busy    = (r_state == S_INIT) | (r_state == S_RUN) | (r_state == S_FLUSH);
  assign bus.done    = (r_state == S_DONE);
  assign bus.pass    = (r_state == S_DONE) & (r_misr == GOLDEN);
  assign bus.sign    = r_misr;
  assign bus.pat_cnt = r_pat_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: a per-cycle vector table plus hand-written abort, reset and signature sequences.
module tb_bist_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bist_seq_ctrl_if if_a ();
  bist_seq_ctrl_if if_b ();
  bist_seq_ctrl_if if_c ();
  logic [2:0] st_a, st_b, st_c;

  bist_seq_ctrl #(.N_PAT(3), .INIT_CYC(4), .LFSR_SEED(8'hA5), .MISR_SEED(8'h00), .GOLDEN(8'h00))
    dut_a (.i_ck(clk), .i_rst(rst), .bus(if_a.slave), .o_state(st_a));
  bist_seq_ctrl #(.N_PAT(2), .INIT_CYC(4), .LFSR_SEED(8'hA5), .MISR_SEED(8'h00), .GOLDEN(8'h03))
    dut_b (.i_ck(clk), .i_rst(rst), .bus(if_b.slave), .o_state(st_b));
  bist_seq_ctrl #(.N_PAT(2), .INIT_CYC(4), .LFSR_SEED(8'hA5), .MISR_SEED(8'h00), .GOLDEN(8'h00))
    dut_c (.i_ck(clk), .i_rst(rst), .bus(if_c.slave), .o_state(st_c));

  typedef struct {
    logic        start;
    logic        abort;
    logic        g0, g1, g2, busy, done, pass;
    logic [15:0] pat;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit s, bit a, bit g0, bit g1, bit g2, bit busy, bit done, bit pass, int pat);
    vec_t v;
    v.start = s; v.abort = a; v.g0 = g0; v.g1 = g1; v.g2 = g2;
    v.busy = busy; v.done = done; v.pass = pass; v.pat = 16'(pat);
    return v;
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] m, input logic [5:0] d);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {2'b00, d};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " g0"},   {15'd0, if_a.cut_g0}, 16'd0);
    check({tag, " g1"},   {15'd0, if_a.cut_g1}, 16'd0);
    check({tag, " g2"},   {15'd0, if_a.cut_g2}, 16'd0);
    check({tag, " busy"}, {15'd0, if_a.busy},   16'd0);
    check({tag, " done"}, {15'd0, if_a.done},   16'd0);
    check({tag, " pass"}, {15'd0, if_a.pass},   16'd0);
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (!if_a.done && n < 40) begin step(); n++; end
    check({tag, " done within bound"}, {15'd0, if_a.done}, 16'd1);
  endtask

  vec_t tbl[22];
  logic [7:0] exp_sign;

  initial begin
    if_a.start = 0; if_a.abort = 0; if_a.cut_out = 6'h00;
    if_b.start = 0; if_b.abort = 0; if_b.cut_out = 6'h01;
    if_c.start = 0; if_c.abort = 0; if_c.cut_out = 6'h01;

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_zero("reset");
    check("reset sign", {8'd0, if_a.sign}, 16'd0);
    check("reset pat",  if_a.pat_cnt, 16'd0);
    check("reset state", {13'd0, st_a}, 16'd0);
    step(); step();
    rst = 1'b0;

    // N_PAT=3, INIT_CYC=4 run; START pulses during INIT/RUN are ignored; restart from DONE; abort+start -> IDLE.
    tbl[0]  = mk(1,0, 1,0,0, 1,0,0, 0);
    tbl[1]  = mk(0,0, 1,0,0, 1,0,0, 0);
    tbl[2]  = mk(1,0, 1,0,0, 1,0,0, 0);
    tbl[3]  = mk(0,0, 1,0,0, 1,0,0, 0);
    tbl[4]  = mk(0,0, 0,1,0, 1,0,0, 0);
    tbl[5]  = mk(1,0, 0,0,1, 1,0,0, 1);
    tbl[6]  = mk(0,0, 0,1,0, 1,0,0, 2);
    tbl[7]  = mk(0,0, 0,0,0, 1,0,0, 3);
    tbl[8]  = mk(0,0, 0,0,0, 0,1,1, 3);
    tbl[9]  = mk(0,0, 0,0,0, 0,1,1, 3);
    tbl[10] = mk(1,0, 1,0,0, 1,0,0, 0);
    tbl[11] = mk(0,0, 1,0,0, 1,0,0, 0);
    tbl[12] = mk(0,0, 1,0,0, 1,0,0, 0);
    tbl[13] = mk(0,0, 1,0,0, 1,0,0, 0);
    tbl[14] = mk(0,0, 0,1,0, 1,0,0, 0);
    tbl[15] = mk(0,0, 0,0,1, 1,0,0, 1);
    tbl[16] = mk(0,0, 0,1,0, 1,0,0, 2);
    tbl[17] = mk(0,0, 0,0,0, 1,0,0, 3);
    tbl[18] = mk(0,0, 0,0,0, 0,1,1, 3);
    tbl[19] = mk(1,1, 0,0,0, 0,0,0, 3);
    tbl[20] = mk(1,0, 1,0,0, 1,0,0, 0);
    tbl[21] = mk(0,1, 0,0,0, 0,0,0, 0);

    for (int i = 0; i < 22; i++) begin
      if_a.start = tbl[i].start;
      if_a.abort = tbl[i].abort;
      step();
      check($sformatf("row%0d g0", i),   {15'd0, if_a.cut_g0}, {15'd0, tbl[i].g0});
      check($sformatf("row%0d g1", i),   {15'd0, if_a.cut_g1}, {15'd0, tbl[i].g1});
      check($sformatf("row%0d g2", i),   {15'd0, if_a.cut_g2}, {15'd0, tbl[i].g2});
      check($sformatf("row%0d busy", i), {15'd0, if_a.busy},   {15'd0, tbl[i].busy});
      check($sformatf("row%0d done", i), {15'd0, if_a.done},   {15'd0, tbl[i].done});
      check($sformatf("row%0d pass", i), {15'd0, if_a.pass},   {15'd0, tbl[i].pass});
      check($sformatf("row%0d pat", i),  if_a.pat_cnt,         tbl[i].pat);
      check($sformatf("row%0d sign", i), {8'd0, if_a.sign},    16'd0);
    end
    if_a.start = 0; if_a.abort = 0;

    // Abort in the second RUN cycle.
    if_a.start = 1; step(); if_a.start = 0;
    repeat (4) step();
    check("abort pre run1 pat", if_a.pat_cnt, 16'd0);
    step();
    check("abort pre run2 pat", if_a.pat_cnt, 16'd1);
    if_a.abort = 1; step(); if_a.abort = 0;
    check_zero("abort");
    check("abort pat hold", if_a.pat_cnt, 16'd2);
    check("abort state", {13'd0, st_a}, 16'd0);
    step();
    check("abort pat still", if_a.pat_cnt, 16'd2);

    // Reference signature for CUT_OUT=2B over three captures.
    exp_sign = 8'h00;
    repeat (3) exp_sign = misr_next(exp_sign, 6'h2B);
    if_a.cut_out = 6'h2B;

    // Async reset in the middle of RUN, then a clean run.
    if_a.start = 1; step(); if_a.start = 0;
    repeat (6) step();
    check("midrun busy before rst", {15'd0, if_a.busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check_zero("midrun rst");
    check("midrun rst sign", {8'd0, if_a.sign}, 16'd0);
    check("midrun rst pat",  if_a.pat_cnt, 16'd0);
    step();
    rst = 1'b0;
    step();
    if_a.start = 1; step(); if_a.start = 0;
    wait_done_a("rerun");
    check("rerun sign model", {8'd0, if_a.sign}, {8'd0, exp_sign});
    check("rerun sign hand",  {8'd0, if_a.sign}, 16'h00D0);
    check("rerun pass", {15'd0, if_a.pass}, 16'd0);
    check("rerun pat",  if_a.pat_cnt, 16'd3);

    // CUT_OUT tied to 01, N_PAT=2: signature 03, PASS depends on GOLDEN.
    if_b.start = 1; if_c.start = 1; step(); if_b.start = 0; if_c.start = 0;
    check("b pass low while busy", {15'd0, if_b.pass}, 16'd0);
    for (int n = 0; n < 40 && !if_b.done; n++) step();
    check("b done", {15'd0, if_b.done}, 16'd1);
    check("c done", {15'd0, if_c.done}, 16'd1);
    check("b sign", {8'd0, if_b.sign}, 16'h0003);
    check("c sign", {8'd0, if_c.sign}, 16'h0003);
    check("b pass golden03", {15'd0, if_b.pass}, 16'd1);
    check("c pass golden00", {15'd0, if_c.pass}, 16'd0);
    check("b pat", if_b.pat_cnt, 16'd2);

    // START in DONE restarts: DONE drops, G0 rises, signature reloads its seed.
    if_b.start = 1; step(); if_b.start = 0;
    check("b restart done", {15'd0, if_b.done}, 16'd0);
    check("b restart g0",   {15'd0, if_b.cut_g0}, 16'd1);
    check("b restart sign", {8'd0, if_b.sign}, 16'h0000);
    check("b restart pass", {15'd0, if_b.pass}, 16'd0);
    if_b.abort = 1; if_c.abort = 1; step(); if_b.abort = 0; if_c.abort = 0;
    check("b abort busy", {15'd0, if_b.busy}, 16'd0);
    check("c abort sign hold", {8'd0, if_c.sign}, 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
